// File: rtl/if_id_pipeline_ctrl.sv
// if_id_pipeline_ctrl: front-end controller owning the PC and the IF/ID register.
// Applies EX-stage redirects (highest priority) and load-use stalls, requests
// ID/EX bubbles, and keeps saturating stall/flush performance counters.
module if_id_pipeline_ctrl #(
    parameter int unsigned    XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]    NOP_INSTR = 32'h0000_0013,
    parameter int unsigned    CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_stall,
    input  logic                 branch_taken,
    input  logic [XLEN-1:0]      branch_target,
    input  logic [31:0]          imem_instr,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      if_id_pc,
    output logic [31:0]          if_id_instr,
    output logic                 if_id_valid,
    output logic                 id_ex_bubble,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      if_id_pc_q, if_id_pc_d;
    logic [31:0]          if_id_instr_q, if_id_instr_d;
    logic                 if_id_valid_q, if_id_valid_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Redirect wins over stall, so a stall only takes effect without a branch.
    logic stall_apply;
    assign stall_apply = is_stall & ~branch_taken;

    // ID/EX must capture a NOP whenever the front end is redirected or stalled.
    assign id_ex_bubble = branch_taken | is_stall;

    // Next-state controller: every state follows the same redirect > stall > fetch priority.
    always_comb begin
        state_d = RUN;
        unique case (state_q)
            BOOT, RUN: state_d = branch_taken ? FLUSH : (is_stall ? STALL : RUN);
            STALL:     state_d = branch_taken ? FLUSH : (is_stall ? STALL : RUN);
            FLUSH:     state_d = branch_taken ? FLUSH : (is_stall ? STALL : RUN);
            default:   state_d = RUN;
        endcase
    end

    // Datapath next values for PC, IF/ID register and counters.
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        if (branch_taken) begin
            pc_d          = {branch_target[XLEN-1:2], 2'b00};
            if_id_pc_d    = pc_q;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
            end
        end else if (stall_apply) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            end
        end else begin
            pc_d          = pc_q + XLEN'(4);
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_instr;
            if_id_valid_d = 1'b1;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_id_pipeline_ctrl.sv
// Testbench for if_id_pipeline_ctrl: table-driven vectors plus hand-written
// async-reset and counter-saturation sequences.
module tb_if_id_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic        is_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        id_ex_bubble;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    // Narrow-counter instance used for saturation checks.
    logic [31:0] imem_instr4;
    logic [31:0] pc4;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr4;
    logic        if_id_valid4;
    logic        id_ex_bubble4;
    logic [3:0]  stall_count4;
    logic [3:0]  flush_count4;

    int checks;
    int failures;

    if_id_pipeline_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .is_stall      (is_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_instr    (imem_instr),
        .pc            (pc),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .id_ex_bubble  (id_ex_bubble),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    if_id_pipeline_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .is_stall      (is_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_instr    (imem_instr4),
        .pc            (pc4),
        .if_id_pc      (if_id_pc4),
        .if_id_instr   (if_id_instr4),
        .if_id_valid   (if_id_valid4),
        .id_ex_bubble  (id_ex_bubble4),
        .stall_count   (stall_count4),
        .flush_count   (flush_count4)
    );

    // Instruction memory model: instruction word encodes its own address.
    assign imem_instr  = pc  | 32'hA000_0000;
    assign imem_instr4 = pc4 | 32'hA000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_sc;
        logic [31:0] e_fc;
    } vec_t;

    vec_t vecs[16];

    initial begin
        checks   = 0;
        failures = 0;

        //          stall br   tgt            pc             ifpc           instr          v     sc  fc
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h4,         32'h0,         32'hA000_0000, 1'b1, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h8,         32'h4,         32'hA000_0004, 1'b1, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h8,         32'h4,         32'hA000_0004, 1'b1, 1, 0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h8,         32'h4,         32'hA000_0004, 1'b1, 2, 0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'hC,         32'h8,         32'hA000_0008, 1'b1, 2, 0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h10,        32'hC,         32'hA000_000C, 1'b1, 2, 0};
        vecs[6]  = '{1'b1, 1'b1, 32'h100,      32'h100,       32'h10,        32'h0000_0013, 1'b0, 2, 1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h104,       32'h100,       32'hA000_0100, 1'b1, 2, 1};
        vecs[8]  = '{1'b0, 1'b1, 32'h40,       32'h40,        32'h104,       32'h0000_0013, 1'b0, 2, 2};
        vecs[9]  = '{1'b0, 1'b1, 32'h80,       32'h80,        32'h40,        32'h0000_0013, 1'b0, 2, 3};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h84,        32'h80,        32'hA000_0080, 1'b1, 2, 3};
        vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h84,       32'h0000_0013, 1'b0, 2, 4};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 2, 4};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h4,         32'h0,         32'hA000_0000, 1'b1, 2, 4};
        vecs[14] = '{1'b0, 1'b1, 32'h103,      32'h100,       32'h4,         32'h0000_0013, 1'b0, 2, 5};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h104,       32'h100,       32'hA000_0100, 1'b1, 2, 5};

        reset         = 1'b1;
        is_stall      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        #2;
        chk("rst_pc",    pc,                  32'h0);
        chk("rst_ifpc",  if_id_pc,            32'h0);
        chk("rst_instr", if_id_instr,         32'h0000_0013);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_sc",    {16'b0, stall_count}, 32'h0);
        chk("rst_fc",    {16'b0, flush_count}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            is_stall      = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d_bubble", i), {31'b0, id_ex_bubble}, {31'b0, vecs[i].stall | vecs[i].br});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i),    pc,                   vecs[i].e_pc);
            chk($sformatf("v%0d_ifpc", i),  if_id_pc,             vecs[i].e_ifpc);
            chk($sformatf("v%0d_instr", i), if_id_instr,          vecs[i].e_instr);
            chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_sc", i),    {16'b0, stall_count}, vecs[i].e_sc);
            chk($sformatf("v%0d_fc", i),    {16'b0, flush_count}, vecs[i].e_fc);
        end

        // Async reset mid-stall, then long stall for saturation on the 4-bit counter.
        is_stall     = 1'b1;
        branch_taken = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("stall_hold_pc", pc, 32'h104);
        chk("stall_hold_sc", {16'b0, stall_count}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc",     pc,                    32'h0);
        chk("arst_ifpc",   if_id_pc,              32'h0);
        chk("arst_instr",  if_id_instr,           32'h0000_0013);
        chk("arst_valid",  {31'b0, if_id_valid},  32'h0);
        chk("arst_sc",     {16'b0, stall_count},  32'h0);
        chk("arst_fc",     {16'b0, flush_count},  32'h0);
        chk("arst_sc4",    {28'b0, stall_count4}, 32'h0);
        chk("arst_bubble", {31'b0, id_ex_bubble}, 32'h1);
        #1;
        reset = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("long_stall_pc",    pc,                    32'h0);
        chk("long_stall_valid", {31'b0, if_id_valid},  32'h0);
        chk("long_stall_sc",    {16'b0, stall_count},  32'd20);
        chk("sat_sc4",          {28'b0, stall_count4}, 32'd15);
        is_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("resume_pc",    pc,                   32'h4);
        chk("resume_ifpc",  if_id_pc,             32'h0);
        chk("resume_instr", if_id_instr,          32'hA000_0000);
        chk("resume_valid", {31'b0, if_id_valid}, 32'h1);
        chk("sat_hold_sc4", {28'b0, stall_count4}, 32'd15);

        // Async reset mid-flush.
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        @(posedge clk);
        #1;
        chk("flush_pc", pc,                   32'h200);
        chk("flush_fc", {16'b0, flush_count}, 32'd1);
        branch_taken = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("arst_fl_pc",    pc,                   32'h0);
        chk("arst_fl_fc",    {16'b0, flush_count}, 32'h0);
        chk("arst_fl_ifpc",  if_id_pc,             32'h0);
        chk("arst_fl_instr", if_id_instr,          32'h0000_0013);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("boot_pc",    pc,          32'h4);
        chk("boot_instr", if_id_instr, 32'hA000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
